decoder_rrns: RTL and testbench

- Multi-cycle RRNS decoder with error correction for the 9-channel residue code (moduli 64, 63, 65, 67, 71, 73, 79, 83, 89) carrying a 16-bit value.
- Evaluates every 3-modulus subset by mixed-radix conversion and scores each candidate against all 9 received residues. The best-scoring candidate is output (maximum-likelihood decode).
- Corrects up to 3 erroneous residues. Sits on the receive side of the residue channel, after the channel/fault-injection stage.

---
 rtl/decoder_rrns.sv | 227 ++++++++++++++++++++++
 tb/tb_decoder_rrns.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/decoder_rrns.sv
// Multi-cycle maximum-likelihood RRNS decoder for the 9-channel residue code
// (moduli 64,63,65,67,71,73,79,83,89): tries every 3-channel MRC candidate and keeps the best scorer.
module decoder_rrns #(
    parameter int MAX_ERR = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [5:0]  rem_64,
    input  logic [5:0]  rem_63,
    input  logic [6:0]  rem_65,
    input  logic [6:0]  rem_67,
    input  logic [6:0]  rem_71,
    input  logic [6:0]  rem_73,
    input  logic [6:0]  rem_79,
    input  logic [6:0]  rem_83,
    input  logic [6:0]  rem_89,
    output logic        busy,
    output logic [15:0] data_out,
    output logic [3:0]  err_count,
    output logic        uncorrectable,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_MRC1, S_MRC2, S_SCORE, S_UPDATE, S_FINISH
    } state_t;

    localparam logic [3:0] MIN_MATCH = 4'(9 - MAX_ERR);

    function automatic logic [6:0] m_of(input logic [3:0] c);
        case (c)
            4'd0:    m_of = 7'd64;
            4'd1:    m_of = 7'd63;
            4'd2:    m_of = 7'd65;
            4'd3:    m_of = 7'd67;
            4'd4:    m_of = 7'd71;
            4'd5:    m_of = 7'd73;
            4'd6:    m_of = 7'd79;
            4'd7:    m_of = 7'd83;
            default: m_of = 7'd89;
        endcase
    endfunction

    // Each arm reduces by a constant, so the runtime channel select is only a mux.
    function automatic logic [6:0] mod_m(input logic [19:0] x, input logic [3:0] c);
        case (c)
            4'd0:    mod_m = 7'(x % 20'd64);
            4'd1:    mod_m = 7'(x % 20'd63);
            4'd2:    mod_m = 7'(x % 20'd65);
            4'd3:    mod_m = 7'(x % 20'd67);
            4'd4:    mod_m = 7'(x % 20'd71);
            4'd5:    mod_m = 7'(x % 20'd73);
            4'd6:    mod_m = 7'(x % 20'd79);
            4'd7:    mod_m = 7'(x % 20'd83);
            default: mod_m = 7'(x % 20'd89);
        endcase
    endfunction

    function automatic int inv_mod(input int a, input int m);
        int t, nt, r, nr, q, tmp;
        t = 0; nt = 1; r = m; nr = a % m;
        while (nr != 0) begin
            q = r / nr;
            tmp = t - q * nt; t = nt; nt = tmp;
            tmp = r - q * nr; r = nr; nr = tmp;
        end
        if (t < 0) t = t + m;
        return t;
    endfunction

    // INV[a*9+b] = inverse of m_a modulo m_b; built at elaboration.
    function automatic logic [80:0][6:0] gen_inv();
        logic [80:0][6:0] t;
        t = '0;
        for (int a = 0; a < 9; a++)
            for (int b = 0; b < 9; b++)
                if (a != b)
                    t[a*9+b] = 7'(inv_mod(int'(m_of(4'(a))), int'(m_of(4'(b)))));
        return t;
    endfunction

    localparam logic [80:0][6:0] INV = gen_inv();

    state_t            r_state, w_state_nxt;
    logic [8:0][6:0]   r_res;
    logic [8:0]        r_valid;
    logic [3:0]        r_i, r_j, r_k;
    logic [6:0]        r_a1, r_a2;
    logic              r_skip;
    logic [19:0]       r_x;
    logic [3:0]        r_match;
    logic [3:0]        r_best_score;
    logic [15:0]       r_best_val;
    logic              r_found;

    logic [6:0]  w_ij, w_ik, w_jk;
    logic [6:0]  w_m_i, w_m_j, w_m_k;
    logic [6:0]  w_d1, w_a1, w_t, w_d2, w_inv2, w_a2;
    logic [19:0] w_x;
    logic [3:0]  w_match;
    logic        w_elig;

    assign w_ij  = 7'(r_i) * 7'd9 + 7'(r_j);
    assign w_ik  = 7'(r_i) * 7'd9 + 7'(r_k);
    assign w_jk  = 7'(r_j) * 7'd9 + 7'(r_k);
    assign w_m_i = m_of(r_i);
    assign w_m_j = m_of(r_j);
    assign w_m_k = m_of(r_k);

    // MRC digit 1: subtraction biased by m_j so it never goes negative.
    assign w_d1 = mod_m(20'(r_res[r_j]) + 20'(w_m_j) - 20'(mod_m(20'(r_res[r_i]), r_j)), r_j);
    assign w_a1 = mod_m(20'(w_d1) * 20'(INV[w_ij]), r_j);

    // MRC digit 2: inv(m_i*m_j) mod m_k is the product of the two pairwise inverses.
    assign w_t    = mod_m(20'(r_res[r_i]) + 20'(w_m_i) * 20'(r_a1), r_k);
    assign w_d2   = mod_m(20'(r_res[r_k]) + 20'(w_m_k) - 20'(w_t), r_k);
    assign w_inv2 = mod_m(20'(INV[w_ik]) * 20'(INV[w_jk]), r_k);
    assign w_a2   = mod_m(20'(w_d2) * 20'(w_inv2), r_k);

    assign w_x = 20'(r_res[r_i]) + 20'(w_m_i) * 20'(r_a1)
               + 20'(w_m_i) * 20'(w_m_j) * 20'(r_a2);

    always_comb begin
        w_match = '0;
        for (int c = 0; c < 9; c++)
            if (r_valid[c] && (mod_m(w_x, 4'(c)) == r_res[c]))
                w_match = w_match + 4'd1;
    end

    assign w_elig = !r_skip && (r_x <= 20'd65535) && (r_match > r_best_score);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_nxt = S_LOAD;
            S_LOAD:   w_state_nxt = S_MRC1;
            S_MRC1:   w_state_nxt = S_MRC2;
            S_MRC2:   w_state_nxt = S_SCORE;
            S_SCORE:  w_state_nxt = S_UPDATE;
            S_UPDATE: w_state_nxt = (r_i == 4'd6) ? S_FINISH : S_MRC1;
            S_FINISH: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res         <= '0;
            r_valid       <= '0;
            r_i           <= '0;
            r_j           <= '0;
            r_k           <= '0;
            r_a1          <= '0;
            r_a2          <= '0;
            r_skip        <= 1'b0;
            r_x           <= '0;
            r_match       <= '0;
            r_best_score  <= '0;
            r_best_val    <= '0;
            r_found       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            data_out      <= '0;
            err_count     <= '0;
            uncorrectable <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: if (start) begin
                    r_res        <= {rem_89, rem_83, rem_79, rem_73, rem_71, rem_67, rem_65,
                                     1'b0, rem_63, 1'b0, rem_64};
                    r_best_score <= '0;
                    r_best_val   <= '0;
                    r_found      <= 1'b0;
                    r_i          <= 4'd0;
                    r_j          <= 4'd1;
                    r_k          <= 4'd2;
                    busy         <= 1'b1;
                end
                S_LOAD:
                    for (int c = 0; c < 9; c++)
                        r_valid[c] <= (r_res[c] < m_of(4'(c)));
                S_MRC1: begin
                    r_a1   <= w_a1;
                    r_skip <= !(r_valid[r_i] && r_valid[r_j] && r_valid[r_k]);
                end
                S_MRC2:  r_a2 <= w_a2;
                S_SCORE: begin
                    r_x     <= w_x;
                    r_match <= w_match;
                end
                S_UPDATE: begin
                    if (w_elig) begin
                        r_best_val   <= r_x[15:0];
                        r_best_score <= r_match;
                        r_found      <= 1'b1;
                    end
                    if (r_k != 4'd8) begin
                        r_k <= r_k + 4'd1;
                    end else if (r_j != 4'd7) begin
                        r_j <= r_j + 4'd1;
                        r_k <= r_j + 4'd2;
                    end else begin
                        r_i <= r_i + 4'd1;
                        r_j <= r_i + 4'd2;
                        r_k <= r_i + 4'd3;
                    end
                end
                S_FINISH: begin
                    done          <= 1'b1;
                    busy          <= 1'b0;
                    data_out      <= r_found ? r_best_val : 16'd0;
                    err_count     <= r_found ? (4'd9 - r_best_score) : 4'd9;
                    uncorrectable <= !r_found || (r_best_score < MIN_MATCH);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_rrns.sv
// Directed-vector bench for decoder_rrns: clean words, corrected errors, invalid residues,
// start-while-busy and mid-decode reset.
module tb_decoder_rrns;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  rem_64 = '0, rem_63 = '0;
    logic [6:0]  rem_65 = '0, rem_67 = '0, rem_71 = '0, rem_73 = '0;
    logic [6:0]  rem_79 = '0, rem_83 = '0, rem_89 = '0;
    logic        busy, uncorrectable, done;
    logic [15:0] data_out;
    logic [3:0]  err_count;

    int n_chk = 0;
    int n_err = 0;

    decoder_rrns #(.MAX_ERR(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .rem_64(rem_64), .rem_63(rem_63), .rem_65(rem_65), .rem_67(rem_67),
        .rem_71(rem_71), .rem_73(rem_73), .rem_79(rem_79), .rem_83(rem_83),
        .rem_89(rem_89),
        .busy(busy), .data_out(data_out), .err_count(err_count),
        .uncorrectable(uncorrectable), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [8:0][6:0] r;
        logic [15:0]     d;
        logic [3:0]      e;
        logic            u;
    } vec_t;

    vec_t tv [8];

    function automatic vec_t mk(input int a0, a1, a2, a3, a4, a5, a6, a7, a8,
                                input int d, e, u);
        vec_t v;
        v.r[0] = 7'(a0); v.r[1] = 7'(a1); v.r[2] = 7'(a2);
        v.r[3] = 7'(a3); v.r[4] = 7'(a4); v.r[5] = 7'(a5);
        v.r[6] = 7'(a6); v.r[7] = 7'(a7); v.r[8] = 7'(a8);
        v.d = 16'(d); v.e = 4'(e); v.u = 1'(u);
        return v;
    endfunction

    task chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task apply(input vec_t v);
        rem_64 = v.r[0][5:0]; rem_63 = v.r[1][5:0]; rem_65 = v.r[2];
        rem_67 = v.r[3];      rem_71 = v.r[4];      rem_73 = v.r[5];
        rem_79 = v.r[6];      rem_83 = v.r[7];      rem_89 = v.r[8];
    endtask

    // Starts a decode of v; if poke_at > 0, re-pulses start with poke_v that many cycles in.
    task run(input string tag, input vec_t v, input int poke_at, input vec_t poke_v);
        int lat;
        logic busy_ok;
        @(negedge clk);
        apply(v);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        busy_ok = 1'b1;
        for (int c = 1; c <= 400; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                lat = c;
                break;
            end
            if (!busy) busy_ok = 1'b0;
            if (c == poke_at) begin
                apply(poke_v);
                start = 1'b1;
            end
        end
        chk({tag, " latency"}, lat, 338);
        chk({tag, " busy held"}, busy_ok, 1);
        chk({tag, " busy low at done"}, busy, 0);
        chk({tag, " data_out"}, data_out, v.d);
        chk({tag, " err_count"}, err_count, v.e);
        chk({tag, " uncorrectable"}, uncorrectable, v.u);
        @(posedge clk);
        #1;
        chk({tag, " done one cycle"}, done, 0);
        chk({tag, " data held"}, data_out, v.d);
    endtask

    initial begin
        logic seen_done;

        tv[0] = mk(57, 60, 60, 17, 62,  8, 21, 61, 63, 12345, 0, 0); // clean
        tv[1] = mk( 0, 60, 60, 17,  0,  8, 21, 61,  0, 12345, 3, 0); // 3 errors
        tv[2] = mk(63, 15, 15,  9,  2, 54, 44, 48, 31, 65535, 0, 0); // upper bound
        tv[3] = mk( 0,  0,  0,  0,  0,  0,  0,  0,  0,     0, 0, 0); // zero
        tv[4] = mk(57, 60,127, 17, 62,  8, 21, 61, 63, 12345, 1, 0); // invalid rem_65
        tv[5] = mk( 0, 63,127,127,127,127,127,127,127,     0, 9, 1); // only ch0 valid
        tv[6] = mk( 0,  1,  0,  0,  0,  0,  0,  5,  0,     0, 2, 0); // 2 errors on zero
        tv[7] = mk( 0, 15, 15,  9,  2, 54, 44, 48, 31, 65535, 1, 0); // 1 error on max

        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset data_out", data_out, 0);
        chk("reset err_count", err_count, 0);
        chk("reset uncorrectable", uncorrectable, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < 8; n++)
            run($sformatf("vec%0d", n), tv[n], 0, tv[0]);

        // Second start mid-decode with other residues must not disturb the first result.
        run("restart ignored", tv[0], 100, tv[2]);

        // Reset partway through: outputs clear at once and no done follows.
        @(negedge clk);
        apply(tv[2]);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (200) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort data_out", data_out, 0);
        chk("abort err_count", err_count, 0);
        chk("abort uncorrectable", uncorrectable, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            #1;
            if (done || busy) seen_done = 1'b1;
        end
        chk("abort no done", seen_done, 0);

        run("after abort", tv[2], 0, tv[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
